// File: rtl/counter_share_arbiter_if.sv
// Requester-side bundle for the shared-counter arbiter: request/terminal-count in,
// grant/completion/count status out.
interface counter_share_arbiter_if #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) ();
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] len;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [W-1:0]      q;

    modport master (
        output req,
        output len,
        input  gnt,
        input  done,
        input  busy,
        input  q
    );

    modport slave (
        input  req,
        input  len,
        output gnt,
        output done,
        output busy,
        output q
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin owner of a single shared up-counter: grants one requester, counts 0..len,
// pulses done, then releases. All outputs are registered.
module counter_share_arbiter #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 4
) (
    input logic                    clk,
    input logic                    rst,
    counter_share_arbiter_if.slave bus
);
    localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [W-1:0]    target_q, target_d;
    logic [W-1:0]    cnt_q, cnt_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [NREQ-1:0] done_q, done_d;
    logic            busy_q, busy_d;

    logic [IdxW-1:0] win_idx;
    logic [IdxW-1:0] cand;
    logic            win_found;
    logic            owner_req;
    logic            at_target;

    // last_q doubles as the current owner index while RUN/DONE.
    assign owner_req = bus.req[last_q];
    assign at_target = (cnt_q == target_q);

    // First requester in order last+1, last+2, ... modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = last_q;
        cand      = last_q;
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IdxW'((32'(last_q) + off) % NREQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= StIdle;
            last_q   <= IdxW'(NREQ - 1);
            target_q <= '0;
            cnt_q    <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            last_q   <= last_d;
            target_q <= target_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Abort outranks completion on the same edge.
                if (!owner_req) begin
                    state_d = StIdle;
                end else if (at_target) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Next values of the registered outputs and the grant bookkeeping.
    always_comb begin
        gnt_d    = '0;
        done_d   = '0;
        busy_d   = 1'b0;
        cnt_d    = '0;
        target_d = target_q;
        last_d   = last_q;
        unique case (state_q)
            StIdle: begin
                if (win_found) begin
                    gnt_d[win_idx] = 1'b1;
                    busy_d         = 1'b1;
                    target_d       = bus.len[32'(win_idx) * W +: W];
                    last_d         = win_idx;
                end
            end
            StRun: begin
                if (owner_req) begin
                    busy_d = 1'b1;
                    if (at_target) begin
                        done_d[last_q] = 1'b1;
                        cnt_d          = cnt_q;
                    end else begin
                        gnt_d[last_q] = 1'b1;
                        cnt_d         = cnt_q + 1'b1;
                    end
                end
            end
            StDone: begin
                cnt_d = '0;
            end
            default: begin
                cnt_d = '0;
            end
        endcase
    end

    assign bus.gnt  = gnt_q;
    assign bus.done = done_q;
    assign bus.busy = busy_q;
    assign bus.q    = cnt_q;

    a_gnt_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));
    a_done_onehot: assert property (@(posedge clk) disable iff (!rst) $onehot0(done_q));
    a_gnt_done_excl: assert property (@(posedge clk) disable iff (!rst) (gnt_q & done_q) == '0);

endmodule

// File: tb/tb_counter_share_arbiter.sv
// Scoreboarded bench: the driver predicts each grant from a round-robin model and queues it;
// a negedge monitor pops and checks the full grant/count/done trace.
module tb_counter_share_arbiter;
    localparam int NREQ = 4;
    localparam int W    = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    counter_share_arbiter_if #(.NREQ(NREQ), .W(W)) bif ();

    counter_share_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bif)
    );

    typedef struct {
        int win;
        int len;
        int stop;
        bit abort;
        int gap;
    } exp_t;

    exp_t expq[$];
    int   n_cmp      = 0;
    int   n_fail     = 0;
    int   model_last = NREQ - 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        for (int i = 1; i <= NREQ; i++) begin
            if (mask[(last + i) % NREQ]) return (last + i) % NREQ;
        end
        return -1;
    endfunction

    // Called while the DUT is in IDLE; returns in the following IDLE cycle.
    // abort_at: -1 run to completion, -2 random abort point, else abort when q == abort_at.
    task automatic issue(input logic [NREQ-1:0] mask, input logic [NREQ*W-1:0] lens,
                         input int abort_at, input int gap, input bit do_reset);
        exp_t r;
        int   win;
        int   l;
        win = rr_pick(model_last, mask);
        l   = int'(lens[win*W +: W]);
        if (abort_at == -2) abort_at = $urandom_range(0, l);
        r.win   = win;
        r.len   = l;
        r.abort = (abort_at >= 0);
        r.stop  = (abort_at >= 0) ? abort_at : l;
        r.gap   = gap;
        expq.push_back(r);
        model_last = win;
        bif.req = mask;
        bif.len = lens;
        @(posedge clk); #1;
        if (abort_at >= 0) begin
            repeat (abort_at) begin
                @(posedge clk); #1;
                if ($urandom_range(1) == 1) bif.len = (NREQ*W)'($urandom);
            end
            if (do_reset) begin
                rst        = 1'b0;
                model_last = NREQ - 1;
            end else begin
                bif.req[win] = 1'b0;
            end
            @(posedge clk); #1;
            rst = 1'b1;
        end else begin
            repeat (l + 1) begin
                @(posedge clk); #1;
                if ($urandom_range(1) == 1) bif.len = (NREQ*W)'($urandom);
            end
            bif.req = '0;
            @(posedge clk); #1;
        end
    endtask

    // Monitor: every negedge, either checks the quiet IDLE outputs or follows one grant.
    initial begin
        exp_t r;
        int   idle_cnt;
        idle_cnt = 0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (bif.gnt == '0) begin
                chk("idle_done", int'(bif.done), 0);
                chk("idle_busy", int'(bif.busy), 0);
                chk("idle_q", int'(bif.q), 0);
                idle_cnt++;
            end else if (expq.size() == 0) begin
                chk("unexpected_grant", int'(bif.gnt), 0);
            end else begin
                r = expq.pop_front();
                chk("grant_owner", int'(bif.gnt), 1 << r.win);
                chk("grant_q", int'(bif.q), 0);
                chk("grant_busy", int'(bif.busy), 1);
                chk("grant_done", int'(bif.done), 0);
                if (r.gap >= 0) chk("grant_gap", idle_cnt, r.gap);
                for (int k = 1; k <= r.stop; k++) begin
                    @(negedge clk);
                    chk("run_gnt", int'(bif.gnt), 1 << r.win);
                    chk("run_q", int'(bif.q), k);
                    chk("run_busy", int'(bif.busy), 1);
                    chk("run_done", int'(bif.done), 0);
                end
                @(negedge clk);
                if (r.abort) begin
                    chk("abort_gnt", int'(bif.gnt), 0);
                    chk("abort_done", int'(bif.done), 0);
                    chk("abort_busy", int'(bif.busy), 0);
                    chk("abort_q", int'(bif.q), 0);
                end else begin
                    chk("done_pulse", int'(bif.done), 1 << r.win);
                    chk("done_gnt", int'(bif.gnt), 0);
                    chk("done_busy", int'(bif.busy), 1);
                    chk("done_q", int'(bif.q), r.len);
                    @(negedge clk);
                    chk("release_gnt", int'(bif.gnt), 0);
                    chk("release_done", int'(bif.done), 0);
                    chk("release_busy", int'(bif.busy), 0);
                    chk("release_q", int'(bif.q), 0);
                end
                idle_cnt = 1;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks pending", expq.size());
        $fatal(1);
    end

    initial begin
        int g;
        bif.req = '0;
        bif.len = '0;
        rst     = 1'b0;
        repeat (2) begin
            bif.req = NREQ'($urandom);
            @(posedge clk); #1;
        end
        rst = 1'b1;

        issue(4'b1111, 16'h0000, -1, -1, 1'b0);   // requester 0 first after reset
        issue(4'b0001, 16'h0003, -1, 1, 1'b0);
        repeat (5) issue(4'b1111, 16'h0000, -1, 1, 1'b0);
        issue(4'b0100, 16'h0900, 2, 1, 1'b0);
        issue(4'b0010, 16'h00F0, -1, 1, 1'b0);
        issue(4'b1000, 16'h9000, 5, 1, 1'b1);     // reset while q == 5
        issue(4'b1010, 16'h0040, -1, 1, 1'b0);
        issue(4'b0100, 16'h0500, 5, 1, 1'b0);     // abort on the terminal edge

        for (int t = 0; t < 40; t++) begin
            g       = $urandom_range(0, 2);
            bif.req = '0;
            repeat (g) begin
                @(posedge clk); #1;
            end
            issue(NREQ'($urandom_range(1, 15)), (NREQ*W)'($urandom),
                  ($urandom_range(3) == 0) ? -2 : -1, 1 + g, 1'b0);
        end

        bif.req = '0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
